// File: rtl/mac_pe_pkg.sv
// mac_pe_pkg: shared types and helpers for the mac_pe_seq processing element.
//   pe_state_e    - sequencing FSM states (IDLE/RUN/FLUSH/OUT)
//   DEF_*         - default datapath widths
//   add_overflow  - signed-add overflow detect from operand/result sign bits
package mac_pe_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ACC_W  = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } pe_state_e;

    // A two's-complement add overflows exactly when both operands share a
    // sign and the sum's sign differs from it. Width-independent.
    function automatic logic add_overflow(input logic a_sign,
                                          input logic b_sign,
                                          input logic sum_sign);
        return (a_sign == b_sign) && (sum_sign != a_sign);
    endfunction

endpackage

// File: rtl/pe_weight_ram.sv
// pe_weight_ram: DEPTH x DATA_W weight store, block-RAM inferable.
//   aclk     - clock
//   wr_en    - write strobe (caller qualifies state and address range)
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data updates on the following edge
//   rd_addr  - read address
//   rd_data  - registered read data (one-cycle latency)
module pe_weight_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch; a reset would stop the tools
    // mapping it onto block RAM, and the weights must survive a reset anyway.
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values, independent of statement or block ordering.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mac_pe_seq.sv
// mac_pe_seq: signed fixed-point MAC processing element.
// Streams cfg_len activations, multiplies beat k by weight[k] and accumulates
// into an ACC_W accumulator (ACC_W must be >= 2*DATA_W), presenting one result
// per run on a valid/ready port.
//   aclk, aresetn              - clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data      - weight preload port, honoured only in IDLE
//   start, cfg_len             - start a run of 0..DEPTH beats
//   busy                       - high whenever the FSM is not IDLE
//   ain_valid/ain_ready/ain    - activation stream
//   res_valid/res_ready        - result handshake
//   res_data, overflow         - dot product and sticky wrap flag
// Pipeline: S0 accept + weight read, S1 multiply, S2 accumulate.
// cfg_len above DEPTH is outside the supported range.
module mac_pe_seq
    import mac_pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_len,
    output logic              busy,
    input  logic              ain_valid,
    output logic              ain_ready,
    input  logic [DATA_W-1:0] ain,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              overflow
);

    localparam int PROD_W = 2 * DATA_W;

    pe_state_e state_q, state_d;

    logic [ADDR_W:0]           len_q, cnt_q, cnt_inc;
    logic                      accept, last_beat, ram_we;
    logic [DATA_W-1:0]         wt_rd;
    logic signed [DATA_W-1:0]  act_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   acc_q, prod_ext, acc_sum;
    logic                      v0_q, v1_q, ovf_q;

    assign accept    = (state_q == RUN) && ain_valid;
    assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);
    assign last_beat = (cnt_inc == len_q);
    assign ram_we    = wr_en && (state_q == IDLE) && (int'(wr_addr) < DEPTH);

    pe_weight_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (cnt_q[ADDR_W-1:0]),
        .rd_data (wt_rd)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        ain_ready = 1'b0;
        res_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_len == '0) ? OUT : RUN;
                end
            end
            RUN: begin
                ain_ready = 1'b1;
                if (accept && last_beat) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Once S0 is empty, the beat still in S1 lands in the
                // accumulator on this very edge, so OUT sees the final sum.
                if (!v0_q) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, counter, accumulator and stage valid bits.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            len_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
        end else begin
            v0_q <= accept;
            v1_q <= v0_q;
            if (state_q == IDLE && start) begin
                len_q <= cfg_len;
                cnt_q <= '0;
                acc_q <= '0;
                ovf_q <= 1'b0;
            end
            if (accept) begin
                cnt_q <= cnt_inc;
            end
            if (v1_q) begin
                acc_q <= acc_sum;
                if (add_overflow(acc_q[ACC_W-1], prod_ext[ACC_W-1], acc_sum[ACC_W-1])) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // Pipeline data registers carry no reset: the valid bits gate them.
    always_ff @(posedge aclk) begin
        if (accept) begin
            act_q <= ain;
        end
        if (v0_q) begin
            prod_q <= PROD_W'(act_q) * PROD_W'($signed(wt_rd));
        end
    end

    assign prod_ext = ACC_W'(prod_q);
    assign acc_sum  = acc_q + prod_ext;

    assign res_data = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_pe_seq.sv
module tb_mac_pe_seq;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic [4:0]  cfg_len = '0;
    logic        busy;
    logic        ain_valid = 1'b0;
    logic        ain_ready;
    logic [15:0] ain = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int wt_m [16];

    mac_pe_seq #(.DATA_W(16), .DEPTH(16), .ACC_W(32)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .cfg_len   (cfg_len),
        .busy      (busy),
        .ain_valid (ain_valid),
        .ain_ready (ain_ready),
        .ain       (ain),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .overflow  (overflow)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: exact products summed in 64-bit, wrapped to 32 bits
    // after every add; overflow when an exact partial sum leaves int32 range.
    function automatic void model_run(input int len, input int acts[16],
                                      output logic [31:0] res, output logic ovf);
        longint acc = 0;
        longint s;
        logic signed [31:0] wrapped;
        ovf = 1'b0;
        for (int k = 0; k < len; k++) begin
            s = acc + longint'(acts[k]) * longint'(wt_m[k]);
            if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf = 1'b1;
            wrapped = s[31:0];
            acc = wrapped;
        end
        res = acc[31:0];
    endfunction

    task automatic write_weight(input int addr, input int val);
        wr_en = 1'b1; wr_addr = 4'(addr); wr_data = 16'(val);
        @(posedge aclk); #1;
        wr_en = 1'b0;
        wt_m[addr] = val;
    endtask

    // Runs one job from IDLE. mode: 0 continuous, 1 idle cycle after each
    // beat, 2 random gaps. inject: weight write + second start mid-RUN.
    task automatic run_job(input int len, input int acts[16], input int mode, input bit inject,
                           output logic [31:0] res, output logic ovf, output int lat,
                           output bit tmo, output bit ready_drop);
        int idx = 0;
        int cyc = 0;
        bit prev_beat = 1'b0;
        bit rdy;
        tmo = 1'b0; ready_drop = 1'b0;
        res_ready = 1'b1;
        start = 1'b1; cfg_len = 5'(len);
        @(posedge aclk); #1;
        start = 1'b0; cyc = 1;
        while (!res_valid) begin
            if (cyc >= 200) begin tmo = 1'b1; break; end
            if (idx < len && !ain_ready) ready_drop = 1'b1;
            ain_valid = ain_ready && (idx < len) &&
                        (mode == 0 || (mode == 1 && !prev_beat) ||
                         (mode == 2 && $urandom_range(3) != 0));
            ain = ain_valid ? 16'(acts[idx]) : 16'($urandom);
            if (inject && cyc == 2) begin
                wr_en = 1'b1; wr_addr = 4'(len - 1); wr_data = 16'(wt_m[len-1] + 1);
                start = 1'b1; cfg_len = 5'd1;
            end
            rdy = ain_ready;
            @(posedge aclk); #1;
            wr_en = 1'b0; start = 1'b0;
            prev_beat = ain_valid && rdy;
            if (prev_beat) idx++;
            cyc++;
        end
        ain_valid = 1'b0;
        lat = cyc; res = res_data; ovf = overflow;
        if (!tmo) begin @(posedge aclk); #1; end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (ain_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ain_ready: got %b expected 0", ain_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_checks++; if (res_data !== 32'd0) begin n_errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        int acts[16];
        logic [31:0] r; logic o; int lat; bit tmo, rd;
        for (int i = 0; i < 4; i++) begin write_weight(i, i + 1); acts[i] = i + 1; end
        run_job(4, acts, 0, 1'b0, r, o, lat, tmo, rd);
        n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL basic_timeout: no res_valid within bound"); end
        n_checks++; if (r !== 32'd30) begin n_errors++; $display("FAIL basic_res: got %0d expected 30", $signed(r)); end
        n_checks++; if (o !== 1'b0) begin n_errors++; $display("FAIL basic_ovf: got %b expected 0", o); end
        n_checks++; if (lat !== 7) begin n_errors++; $display("FAIL basic_latency: got %0d expected 7", lat); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_idle_after: busy %b expected 0", busy); end
    endtask

    task automatic test_gap();
        int acts[16];
        logic [31:0] r; logic o; int lat; bit tmo, rd;
        write_weight(0, -3); write_weight(1, 5);
        acts[0] = 7; acts[1] = -2;
        run_job(2, acts, 1, 1'b0, r, o, lat, tmo, rd);
        n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL gap_timeout: no res_valid within bound"); end
        n_checks++; if (r !== 32'hFFFF_FFE1) begin n_errors++; $display("FAIL gap_res: got %0d expected -31", $signed(r)); end
        n_checks++; if (rd !== 1'b0) begin n_errors++; $display("FAIL gap_ready: ain_ready dropped got 1 expected 0"); end
    endtask

    task automatic test_len_zero();
        res_ready = 1'b0;
        start = 1'b1; cfg_len = 5'd0;
        @(posedge aclk); #1;
        start = 1'b0;
        n_checks++; if (res_valid !== 1'b1) begin n_errors++; $display("FAIL len0_valid: got %b expected 1", res_valid); end
        n_checks++; if (res_data !== 32'd0) begin n_errors++; $display("FAIL len0_data: got %h expected 0", res_data); end
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd0) begin
                n_errors++; $display("FAIL len0_hold: valid %b data %h expected 1 / 0", res_valid, res_data);
            end
        end
        res_ready = 1'b1;
        @(posedge aclk); #1;
        n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_errors++; $display("FAIL len0_release: busy %b valid %b expected 0 / 0", busy, res_valid);
        end
    endtask

    task automatic test_wrap();
        int acts[16];
        logic [31:0] r; logic o; int lat; bit tmo, rd;
        for (int i = 0; i < 16; i++) begin write_weight(i, -32768); acts[i] = -32768; end
        run_job(3, acts, 0, 1'b0, r, o, lat, tmo, rd);
        n_checks++; if (r !== 32'hC000_0000) begin n_errors++; $display("FAIL wrap_res: got %h expected c0000000", r); end
        n_checks++; if (o !== 1'b1) begin n_errors++; $display("FAIL wrap_ovf: got %b expected 1", o); end
        acts[0] = 1;
        run_job(1, acts, 0, 1'b0, r, o, lat, tmo, rd);
        n_checks++; if (r !== 32'hFFFF_8000) begin n_errors++; $display("FAIL wrap_next_res: got %h expected ffff8000", r); end
        n_checks++; if (o !== 1'b0) begin n_errors++; $display("FAIL wrap_next_ovf: got %b expected 0", o); end
    endtask

    task automatic test_ignore_in_run();
        int acts[16];
        logic [31:0] r, e; logic o, eo; int lat; bit tmo, rd;
        for (int i = 0; i < 6; i++) begin
            write_weight(i, int'($urandom_range(2000)) - 1000);
            acts[i] = int'($urandom_range(2000)) - 1000;
        end
        model_run(6, acts, e, eo);
        run_job(6, acts, 0, 1'b1, r, o, lat, tmo, rd);
        n_checks++; if (r !== e) begin n_errors++; $display("FAIL ignore_res: got %0d expected %0d", $signed(r), $signed(e)); end
        n_checks++; if (lat !== 9) begin n_errors++; $display("FAIL ignore_latency: got %0d expected 9", lat); end
        // The weight at len-1 must still be the old one for a follow-up run.
        model_run(6, acts, e, eo);
        run_job(6, acts, 2, 1'b0, r, o, lat, tmo, rd);
        n_checks++; if (r !== e) begin n_errors++; $display("FAIL ignore_rerun: got %0d expected %0d", $signed(r), $signed(e)); end
    endtask

    task automatic test_reset_mid_run();
        int acts[16];
        logic [31:0] r, e; logic o, eo; int lat; bit tmo, rd;
        res_ready = 1'b1;
        start = 1'b1; cfg_len = 5'd8;
        @(posedge aclk); #1;
        start = 1'b0; ain_valid = 1'b1; ain = 16'h0123;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1; ain_valid = 1'b0;
        n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || ain_ready !== 1'b0) begin
            n_errors++; $display("FAIL midreset_state: busy %b valid %b ready %b expected 0 0 0", busy, res_valid, ain_ready);
        end
        n_checks++; if (res_data !== 32'd0) begin n_errors++; $display("FAIL midreset_data: got %h expected 0", res_data); end
        for (int i = 0; i < 16; i++) acts[i] = int'($urandom_range(65535)) - 32768;
        model_run(10, acts, e, eo);
        run_job(10, acts, 2, 1'b0, r, o, lat, tmo, rd);
        n_checks++; if (tmo !== 1'b0 || r !== e || o !== eo) begin
            n_errors++; $display("FAIL midreset_rerun: got %h/%b expected %h/%b (timeout %b)", r, o, e, eo, tmo);
        end
    endtask

    task automatic test_random();
        int acts[16];
        logic [31:0] r, e; logic o, eo; int lat, len, mode; bit tmo, rd;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) begin
                write_weight(i, int'($urandom_range(65535)) - 32768);
                acts[i] = int'($urandom_range(65535)) - 32768;
            end
            len  = int'($urandom_range(16, 1));
            mode = int'($urandom_range(2));
            model_run(len, acts, e, eo);
            run_job(len, acts, mode, 1'b0, r, o, lat, tmo, rd);
            n_checks++; if (tmo !== 1'b0 || r !== e || o !== eo) begin
                n_errors++; $display("FAIL random_%0d: len %0d got %h/%b expected %h/%b (timeout %b)", it, len, r, o, e, eo, tmo);
            end
            if (mode == 0) begin
                n_checks++; if (lat !== len + 3) begin
                    n_errors++; $display("FAIL random_latency_%0d: got %0d expected %0d", it, lat, len + 3);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_len_zero();
        test_wrap();
        test_ignore_in_run();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_pe_seq.md
Name: mac_pe_seq

Overview:
- Next-generation processing element for the vector dot-product array: signed fixed-point MAC with a parametrised local weight RAM, a sequencing FSM and valid/ready handshakes on both input and result.
- Streams LEN activations, multiplies element k by weight[k], accumulates into a wide accumulator and presents one result per run.
- Sits between the activation broadcast bus and the array result collector; weights are preloaded over a simple write port.

Parameters:
- DATA_W, 16, activation/weight width (signed two's complement).
- DEPTH, 16, weight RAM entries and maximum run length.
- ACC_W, 40, accumulator/result width; must be >= 2*DATA_W.
- ADDR_W, $clog2(DEPTH), weight address width (derived).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset.
- wr_en  in  1  weight write strobe.
- wr_addr  in  ADDR_W  weight write address.
- wr_data  in  DATA_W  weight write data.
- start  in  1  start a run (single-cycle pulse).
- cfg_len  in  ADDR_W+1  run length 0..DEPTH, sampled on start.
- busy  out  1  high whenever state != IDLE.
- ain_valid  in  1  activation valid.
- ain_ready  out  1  activation ready.
- ain  in  DATA_W  activation data.
- res_valid  out  1  result valid.
- res_ready  in  1  result ready from collector.
- res_data  out  ACC_W  accumulated dot product.
- overflow  out  1  sticky accumulator wrap flag for the current result.

Behaviour:
- Reset: aresetn, synchronous, active-low. Clears the FSM to IDLE, busy=0, ain_ready=0, res_valid=0, res_data=0, overflow=0, element counter=0, accumulator=0 and the pipeline valid bits. Weight RAM contents are not reset.
- Reset mid-run aborts the run; no result is produced.
- Weight writes: take effect only in IDLE (weight[wr_addr] <= wr_data). They are ignored in every other state. wr_addr >= DEPTH is ignored.
- FSM states: IDLE, RUN, FLUSH, OUT.
  - IDLE -> RUN on start with cfg_len > 0. Latch len, zero the counter and the accumulator, clear overflow.
  - IDLE -> OUT on start with cfg_len == 0. res_data=0.
  - start is ignored outside IDLE.
  - RUN: ain_ready=1. A beat is accepted when ain_valid && ain_ready. Each accepted beat increments the counter.
  - RUN -> FLUSH on the accepting beat that makes counter == len. ain_ready drops in the following cycle.
  - FLUSH: ain_ready=0. Wait until the pipeline is empty, then -> OUT.
  - OUT: res_valid=1. res_data and overflow are held stable until res_valid && res_ready, then -> IDLE.
- Pipeline: 3 stages, one beat per cycle with no bubbles.
  - S0: accept the beat and issue the synchronous weight RAM read at address = counter.
  - S1: signed DATA_W x DATA_W product, 2*DATA_W bits wide.
  - S2: sign-extend the product to ACC_W and add to the accumulator.
  - Latency: the accumulator includes beat k two cycles after acceptance.
  - Minimum start-to-res_valid time, with ain_valid held high: len+3 cycles.
- Arithmetic: the accumulator wraps modulo 2^ACC_W. overflow sets when the signed add overflows and stays set until the next start.
- Gaps in ain_valid stall only S0; in-flight stages still drain.
- res_ready held high in OUT: result handshakes in the first OUT cycle. The next start is accepted from the following cycle, when state is IDLE.

Decomposition:
- Package mac_pe_pkg: state enum (IDLE/RUN/FLUSH/OUT), default widths, and the helper function for signed-add overflow detection.
- Sub-module pe_weight_ram: DEPTH x DATA_W, one synchronous write port and one synchronous read port, block-RAM inferable. The FSM, counter, MAC pipeline and handshakes stay in the top level.

Test Plan:
- Load weights 1..4 at addresses 0..3; start with len=4; stream ain 1,2,3,4 continuously. Required: res_data=30, overflow=0, res_valid first high 7 cycles after start.
- Load weights {-3, 5}; len=2; ain {7, -2} with one idle cycle between beats. Required: res_data=-31, and ain_ready stays high through the gap.
- Start with len=0. Required: OUT on the next cycle, res_data=0. Hold res_ready=0 for 5 cycles: res_valid stays 1 and res_data stays stable; handshake then returns the FSM to IDLE.
- DATA_W=16, ACC_W=32: all weights and all ain = -32768, len=3. Required: the sum 3*2^30 wraps to -1073741824 (0xC0000000) with overflow=1; the next run clears overflow.
- Issue a weight write and a second start during RUN. Required: both are ignored; the result uses the old weights.
- Assert aresetn=0 for one cycle mid-RUN. Required: next cycle busy=0, res_valid=0, ain_ready=0. A fresh run afterwards produces the correct sum using the preserved weights.
